motor_rotation_scheduler: RTL and testbench
===========================================

# motor_rotation_scheduler

Round-robin scheduler that shares a single "run slot" among N motors. Exactly one healthy, enabled motor runs at a time for a fixed period, followed by a dead-time gap with all motors off. The scheduler then hands the slot to the next eligible motor, with wrap-around. It sits between the debounced operator-panel pulses (START/STOP/fault-clear) and the motor output drivers, and generalises the two-motor alternation controller to N motors with fault lockout and a configurable dead time.

## Interface
- N_MOT, 4, number of motors (2..8)
- F_CLK, 25_000_000, clock cycles per second
- T_RUN_S, 30, run period in seconds (normal mode)
- T_TEST_S, 3, run period in seconds (test mode)
- GAP_CYC, 12_500_000, dead-time cycles with all motors off between slots (≥1)

- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- start_p  in  1  one-cycle START pulse (already debounced)
- stop_p  in  1  one-cycle STOP pulse (already debounced)
- fclr_p  in  1  one-cycle pulse that clears all latched faults
- test_mode  in  1  1 selects T_TEST_S, 0 selects T_RUN_S; already synchronised
- en_mask  in  N_MOT  per-motor enable; 0 = excluded from rotation
- fault  in  N_MOT  per-motor fault level; sampled every cycle
- motor_on  out  N_MOT  one-hot or zero motor command (registered)
- cur_idx  out  $clog2(N_MOT)  index of the current or last-run motor
- running  out  1  1 in RUN or GAP
- gap  out  1  1 during dead time
- fault_lat  out  N_MOT  latched fault bits
- no_motor  out  1  sticky: START refused or rotation aborted because no motor was eligible; cleared by the next accepted START

## Operation
- Eligible(i) = en_mask[i] & ~fault_lat[i] & ~fault[i].
- fault_lat[i] sets on any cycle with fault[i]=1. fclr_p clears it, except where fault[i]=1 in that same cycle; set wins.
- States: IDLE, RUN, GAP.
- IDLE
  - All outputs low.
  - On start_p with stop_p=0:
    - If any motor is eligible: select the lowest eligible index, go to RUN, clear no_motor.
    - If none is eligible: set no_motor and stay in IDLE.
- RUN
  - motor_on = one-hot(cur_idx). Period P = (test_mode ? T_TEST_S : T_RUN_S), sampled on RUN entry.
  - A cycle counter runs for P·F_CLK cycles. It restarts on every RUN entry; there is no free-running prescaler.
  - On expiry, go to GAP.
  - If fault[cur_idx]=1 or en_mask[cur_idx]=0: leave RUN immediately and go to GAP (early termination).
- GAP
  - motor_on = 0. Count GAP_CYC cycles.
  - At the end of the gap, search cyclically from cur_idx+1 (mod N_MOT) through cur_idx for the first eligible index.
  - If one is found: load cur_idx and go to RUN. If the search wraps back to cur_idx, the same motor re-runs.
  - If none is found: go to IDLE and set no_motor.
- stop_p in any state returns to IDLE on the next edge with motor_on=0. cur_idx holds its value. stop_p has priority over start_p and all other events.
- start_p in RUN or GAP is ignored.
- Changes to test_mode during RUN take effect from the next RUN entry.
- Reset (rst_n=0 at a clk edge) produces:
  - state=IDLE
  - motor_on=0, cur_idx=0, running=0, gap=0
  - fault_lat=0, no_motor=0
  - counters=0
  - Reset mid-RUN drops motor_on on the next edge.

## Timing
- All outputs are registered. Each event at edge k shows its effect after edge k+1:
  - start_p high in cycle k gives motor_on valid from cycle k+1.
  - RUN lasts exactly P·F_CLK cycles of motor_on high.
  - GAP lasts exactly GAP_CYC cycles of motor_on=0 with gap=1.
  - The next motor is asserted in the cycle after the last gap cycle.
- Fault response: fault[cur_idx] high in cycle k gives motor_on=0 and fault_lat set in cycle k+1.
- Never two bits of motor_on high. Never RUN→RUN without at least GAP_CYC off cycles, including the case where the same motor re-runs.
- Counter width: $clog2(max(T_RUN_S,T_TEST_S)·F_CLK) bits. No wrap occurs inside a period.

## Test plan
Parameters for all scenarios: N_MOT=4, F_CLK=10, T_RUN_S=3, T_TEST_S=1, GAP_CYC=4.

1. Nominal rotation
   - Stimulus: en_mask=4'b1111, start_p at cycle 0.
   - Required: motor_on=0001 for cycles 1–30; 0000 with gap=1 for cycles 31–34; 0010 from cycle 35; order continues 0→1→2→3→0.
2. Mask and re-run
   - Stimulus: en_mask=4'b1010, start_p.
   - Required: motors run in order 1→3→1. With en_mask=4'b0100, motor 2 re-runs after each 4-cycle gap.
3. Fault during RUN
   - Stimulus: fault[0] pulsed at cycle 10 of motor 0's run.
   - Required: motor_on=0 and fault_lat[0]=1 at cycle 11; after 4 gap cycles, motor 1 runs; motor 0 is skipped thereafter until fclr_p.
4. STOP priority
   - Stimulus: start_p and stop_p in the same cycle in IDLE.
   - Required: stays IDLE.
   - Stimulus: stop_p mid-RUN.
   - Required: motor_on=0 and running=0 on the next cycle; cur_idx holds its value.
5. No eligible motor
   - Stimulus: en_mask=0, then start_p.
   - Required: no_motor=1, motor_on stays 0.
   - Stimulus: set en_mask=0001, then start_p.
   - Required: no_motor cleared, motor 0 runs.
6. Test mode and reset
   - Stimulus: test_mode=1 at RUN entry.
   - Required: run lasts 10 cycles.
   - Stimulus: toggle test_mode mid-run.
   - Required: the current run length is unchanged.
   - Stimulus: rst_n=0 mid-RUN.
   - Required: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/motor_rotation_scheduler.sv
// Round-robin run-slot scheduler: one eligible motor runs for a fixed period,
// then all motors are off for a dead-time gap before the slot moves on.
module motor_rotation_scheduler #(
  parameter int N_MOT    = 4,
  parameter int F_CLK    = 25_000_000,
  parameter int T_RUN_S  = 30,
  parameter int T_TEST_S = 3,
  parameter int GAP_CYC  = 12_500_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_p,
  input  logic                     stop_p,
  input  logic                     fclr_p,
  input  logic                     test_mode,
  input  logic [N_MOT-1:0]         en_mask,
  input  logic [N_MOT-1:0]         fault,
  output logic [N_MOT-1:0]         motor_on,
  output logic [$clog2(N_MOT)-1:0] cur_idx,
  output logic                     running,
  output logic                     gap,
  output logic [N_MOT-1:0]         fault_lat,
  output logic                     no_motor
);

  localparam int     IDX_W    = $clog2(N_MOT);
  localparam longint RUN_CYC  = longint'(T_RUN_S) * longint'(F_CLK);
  localparam longint TEST_CYC = longint'(T_TEST_S) * longint'(F_CLK);
  localparam longint MAX_RUN  = (RUN_CYC > TEST_CYC) ? RUN_CYC : TEST_CYC;
  localparam longint MAX_CNT  = (MAX_RUN > longint'(GAP_CYC)) ? MAX_RUN : longint'(GAP_CYC);
  localparam int     CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  // The counter runs 0..limit, so limits are stored as length-1.
  localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYC - 1);
  localparam logic [CNT_W-1:0] TEST_LIM = CNT_W'(TEST_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(longint'(GAP_CYC) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] run_lim;
  logic [N_MOT-1:0] elig;
  logic [IDX_W-1:0] low_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             cur_fail;

  assign elig     = en_mask & ~fault_lat & ~fault;
  assign cur_fail = fault[cur_idx] | ~en_mask[cur_idx];

  // Lowest eligible index for START, and cyclic search from cur_idx+1 for GAP exit.
  always_comb begin
    low_idx = '0;
    nxt_idx = cur_idx;
    for (int i = N_MOT - 1; i >= 0; i--) begin
      if (elig[i]) low_idx = IDX_W'(i);
    end
    for (int k = N_MOT; k >= 1; k--) begin
      if (elig[(int'(cur_idx) + k) % N_MOT]) nxt_idx = IDX_W'((int'(cur_idx) + k) % N_MOT);
    end
  end

  function automatic logic [N_MOT-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = N_MOT'(1) << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      run_lim   <= '0;
      motor_on  <= '0;
      cur_idx   <= '0;
      running   <= 1'b0;
      gap       <= 1'b0;
      fault_lat <= '0;
      no_motor  <= 1'b0;
    end else begin
      fault_lat <= (fclr_p ? '0 : fault_lat) | fault;
      if (stop_p) begin
        state    <= S_IDLE;
        cnt      <= '0;
        motor_on <= '0;
        running  <= 1'b0;
        gap      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_p) begin
              if (|elig) begin
                state    <= S_RUN;
                cnt      <= '0;
                run_lim  <= test_mode ? TEST_LIM : RUN_LIM;
                cur_idx  <= low_idx;
                motor_on <= onehot(low_idx);
                running  <= 1'b1;
                gap      <= 1'b0;
                no_motor <= 1'b0;
              end else begin
                no_motor <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (cur_fail || cnt == run_lim) begin
              state    <= S_GAP;
              cnt      <= '0;
              motor_on <= '0;
              gap      <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (cnt == GAP_LIM) begin
              cnt <= '0;
              gap <= 1'b0;
              if (|elig) begin
                state    <= S_RUN;
                run_lim  <= test_mode ? TEST_LIM : RUN_LIM;
                cur_idx  <= nxt_idx;
                motor_on <= onehot(nxt_idx);
              end else begin
                state    <= S_IDLE;
                running  <= 1'b0;
                no_motor <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            motor_on <= '0;
            running  <= 1'b0;
            gap      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_rotation_scheduler.sv
// Self-checking bench for motor_rotation_scheduler: directed scenarios plus a
// randomized run compared cycle-by-cycle against a slot-level reference model.
module tb_motor_rotation_scheduler;
  localparam int N = 4, F = 10, TR = 3, TT = 1, G = 4;
  localparam int RUN_LEN = TR * F, TEST_LEN = TT * F, SLOT = RUN_LEN + G;

  logic       clk = 1'b0;
  logic       rst_n, start_p, stop_p, fclr_p, test_mode;
  logic [3:0] en_mask, fault;
  logic [3:0] motor_on, fault_lat;
  logic [1:0] cur_idx;
  logic       running, gap, no_motor;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0=idle 1=run 2=gap, with cycles remaining in the phase.
  int         m_phase, m_rem, m_idx, m_j;
  logic [3:0] m_lat, m_el, m_lat_nx;
  logic       m_nm, m_found;

  motor_rotation_scheduler #(
    .N_MOT(N), .F_CLK(F), .T_RUN_S(TR), .T_TEST_S(TT), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .stop_p(stop_p), .fclr_p(fclr_p),
    .test_mode(test_mode), .en_mask(en_mask), .fault(fault), .motor_on(motor_on),
    .cur_idx(cur_idx), .running(running), .gap(gap), .fault_lat(fault_lat),
    .no_motor(no_motor)
  );

  always #5 clk = ~clk;

  // One clock edge: advance the model with the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_rem = 0; m_idx = 0; m_lat = '0; m_nm = 1'b0;
    end else begin
      m_el     = en_mask & ~m_lat & ~fault;
      m_lat_nx = (fclr_p ? 4'b0 : m_lat) | fault;
      if (stop_p) m_phase = 0;
      else if (m_phase == 0) begin
        if (start_p) begin
          if (m_el != 0) begin
            for (int i = 3; i >= 0; i--) if (m_el[i]) m_idx = i;
            m_phase = 1; m_rem = test_mode ? TEST_LEN : RUN_LEN; m_nm = 1'b0;
          end else m_nm = 1'b1;
        end
      end else if (m_phase == 1) begin
        if (fault[m_idx] || !en_mask[m_idx]) begin
          m_phase = 2; m_rem = G;
        end else begin
          m_rem--;
          if (m_rem == 0) begin m_phase = 2; m_rem = G; end
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            m_j = (m_idx + k) % N;
            if (!m_found && m_el[m_j]) begin m_found = 1'b1; m_idx = m_j; end
          end
          if (m_found) begin m_phase = 1; m_rem = test_mode ? TEST_LEN : RUN_LEN; end
          else begin m_phase = 0; m_nm = 1'b1; end
        end
      end
      m_lat = m_lat_nx;
    end
    #1;
  endtask

  task automatic pulse_start();
    start_p = 1'b1; tick(); start_p = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_p = 1'b1; tick(); stop_p = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_p = 0; stop_p = 0; fclr_p = 0; test_mode = 0;
    en_mask = 4'b1111; fault = 4'b0;
    tick(); tick();
    checks++;
    if ({motor_on, cur_idx, running, gap, fault_lat, no_motor} !== 13'b0) begin
      failures++;
      $display("FAIL reset_state: got on=%b idx=%0d run=%b gap=%b lat=%b nm=%b, want all 0",
               motor_on, cur_idx, running, gap, fault_lat, no_motor);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_nominal();
    logic [3:0] e_on;
    en_mask = 4'b1111;
    pulse_start();
    for (int c = 1; c <= 4 * SLOT + 2; c++) begin
      e_on = ((c - 1) % SLOT < RUN_LEN) ? (4'b1 << (((c - 1) / SLOT) % 4)) : 4'b0;
      checks++;
      if (motor_on !== e_on || gap !== ((c - 1) % SLOT >= RUN_LEN)) begin
        failures++;
        $display("FAIL nominal c=%0d: got on=%b gap=%b, want on=%b", c, motor_on, gap, e_on);
      end
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_mask_rerun();
    int seq[3] = '{1, 3, 1};
    logic [3:0] e_on;
    en_mask = 4'b1010;
    pulse_start();
    for (int c = 1; c <= 3 * SLOT; c++) begin
      e_on = ((c - 1) % SLOT < RUN_LEN) ? (4'b1 << seq[(c - 1) / SLOT]) : 4'b0;
      checks++;
      if (motor_on !== e_on) begin
        failures++;
        $display("FAIL mask_1010 c=%0d: got on=%b, want %b", c, motor_on, e_on);
      end
      tick();
    end
    pulse_stop();
    en_mask = 4'b0100;
    pulse_start();
    for (int c = 1; c <= 2 * SLOT + 1; c++) begin
      e_on = ((c - 1) % SLOT < RUN_LEN) ? 4'b0100 : 4'b0;
      checks++;
      if (motor_on !== e_on || cur_idx !== 2'd2) begin
        failures++;
        $display("FAIL rerun_0100 c=%0d: got on=%b idx=%0d, want on=%b idx=2", c, motor_on, cur_idx, e_on);
      end
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_fault();
    int seq[4] = '{1, 2, 3, 1};
    logic [3:0] e_on;
    en_mask = 4'b1111;
    pulse_start();
    for (int c = 1; c < 10; c++) tick();
    checks++;
    if (motor_on !== 4'b0001) begin
      failures++; $display("FAIL fault_pre: got on=%b, want 0001", motor_on);
    end
    fault = 4'b0001; tick(); fault = 4'b0;
    checks++;
    if (motor_on !== 4'b0 || fault_lat !== 4'b0001 || gap !== 1'b1) begin
      failures++;
      $display("FAIL fault_resp: got on=%b lat=%b gap=%b, want 0000/0001/1", motor_on, fault_lat, gap);
    end
    for (int c = 0; c < G; c++) tick();
    for (int c = 0; c < 4 * SLOT; c++) begin
      e_on = (c % SLOT < RUN_LEN) ? (4'b1 << seq[c / SLOT]) : 4'b0;
      checks++;
      if (motor_on !== e_on) begin
        failures++;
        $display("FAIL fault_skip c=%0d: got on=%b, want %b", c, motor_on, e_on);
      end
      tick();
    end
    fclr_p = 1'b1; tick(); fclr_p = 1'b0;
    checks++;
    if (fault_lat !== 4'b0) begin
      failures++; $display("FAIL fault_clear: got lat=%b, want 0000", fault_lat);
    end
    pulse_stop();
    pulse_start();
    checks++;
    if (motor_on !== 4'b0001) begin
      failures++; $display("FAIL fault_after_clr: got on=%b, want 0001", motor_on);
    end
    pulse_stop();
  endtask

  task automatic test_stop();
    start_p = 1'b1; stop_p = 1'b1; tick(); start_p = 1'b0; stop_p = 1'b0;
    checks++;
    if (running !== 1'b0 || motor_on !== 4'b0) begin
      failures++; $display("FAIL stop_vs_start: got run=%b on=%b, want 0/0000", running, motor_on);
    end
    en_mask = 4'b0100;
    pulse_start();
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (motor_on !== 4'b0100) begin
      failures++; $display("FAIL stop_pre: got on=%b, want 0100", motor_on);
    end
    pulse_stop();
    checks++;
    if (motor_on !== 4'b0 || running !== 1'b0 || gap !== 1'b0 || cur_idx !== 2'd2) begin
      failures++;
      $display("FAIL stop_mid_run: got on=%b run=%b gap=%b idx=%0d, want 0000/0/0/2", motor_on, running, gap, cur_idx);
    end
  endtask

  task automatic test_no_motor();
    en_mask = 4'b0;
    pulse_start();
    tick(); tick();
    checks++;
    if (no_motor !== 1'b1 || motor_on !== 4'b0 || running !== 1'b0) begin
      failures++; $display("FAIL no_motor_set: got nm=%b on=%b run=%b, want 1/0000/0", no_motor, motor_on, running);
    end
    en_mask = 4'b0001;
    pulse_start();
    checks++;
    if (no_motor !== 1'b0 || motor_on !== 4'b0001) begin
      failures++; $display("FAIL no_motor_clr: got nm=%b on=%b, want 0/0001", no_motor, motor_on);
    end
    pulse_stop();
  endtask

  task automatic test_test_mode();
    logic e;
    en_mask = 4'b0001; test_mode = 1'b1;
    pulse_start();
    for (int c = 1; c <= TEST_LEN + G + RUN_LEN + 1; c++) begin
      e = (c <= TEST_LEN) || (c > TEST_LEN + G && c <= TEST_LEN + G + RUN_LEN);
      checks++;
      if (motor_on[0] !== e) begin
        failures++; $display("FAIL test_mode c=%0d: got on0=%b, want %b", c, motor_on[0], e);
      end
      if (c == 5) test_mode = 1'b0;
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_reset_mid_run();
    fault = 4'b1000; tick(); fault = 4'b0;
    pulse_start(); tick();
    checks++;
    if (running !== 1'b1 || fault_lat !== 4'b1000) begin
      failures++; $display("FAIL rst_pre: got run=%b lat=%b, want 1/1000", running, fault_lat);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if ({motor_on, cur_idx, running, gap, fault_lat, no_motor} !== 13'b0) begin
      failures++;
      $display("FAIL rst_mid_run: got on=%b idx=%0d run=%b gap=%b lat=%b nm=%b, want all 0",
               motor_on, cur_idx, running, gap, fault_lat, no_motor);
    end
  endtask

  task automatic test_random();
    logic [3:0] e_on;
    for (int c = 0; c < 3000; c++) begin
      start_p = ($urandom_range(0, 15) == 0);
      stop_p  = ($urandom_range(0, 149) == 0);
      fclr_p  = ($urandom_range(0, 59) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      for (int i = 0; i < 4; i++) fault[i] = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0) en_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) test_mode = ~test_mode;
      tick();
      e_on = (m_phase == 1) ? (4'b1 << m_idx) : 4'b0;
      checks++;
      if (motor_on !== e_on || cur_idx !== 2'(m_idx) || running !== (m_phase != 0) ||
          gap !== (m_phase == 2) || fault_lat !== m_lat || no_motor !== m_nm) begin
        failures++;
        $display("FAIL random c=%0d: got on=%b idx=%0d run=%b gap=%b lat=%b nm=%b, want on=%b idx=%0d ph=%0d lat=%b nm=%b",
                 c, motor_on, cur_idx, running, gap, fault_lat, no_motor, e_on, m_idx, m_phase, m_lat, m_nm);
      end
    end
    rst_n = 1'b1; start_p = 0; stop_p = 0; fclr_p = 0; fault = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mask_rerun();
    test_fault();
    test_stop();
    test_no_motor();
    test_test_mode();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
